// File: rtl/sr_drive_controller.sv
// SR latch driver: synchronizes and debounces two button requests, arbitrates,
// and issues exclusive S/R pulses with a guard gap and Q readback check.
module sr_drive_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned PULSE_CYCLES    = 3,
   parameter int unsigned GAP_CYCLES      = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic SET_REQ,
   input  logic RESET_REQ,
   input  logic Q_FB,
   output logic S,
   output logic R,
   output logic BUSY,
   output logic STATE_EXP,
   output logic FAULT
);

   localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] PUL_LAST = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SET  = 3'd1;
   localparam logic [2:0] ST_RST  = 3'd2;
   localparam logic [2:0] ST_GAP  = 3'd3;
   localparam logic [2:0] ST_CHK  = 3'd4;

   logic [1:0]      set_sync_q;
   logic [1:0]      rst_sync_q;
   logic [1:0]      qfb_sync_q;
   logic [1:0]      req_s;

   // index 0 = set request, index 1 = reset request
   logic [1:0]      deb_q;
   logic [1:0]      deb_d;
   logic [1:0][7:0] dcnt_q;
   logic [1:0][7:0] dcnt_d;
   logic [1:0]      ev_q;
   logic [1:0]      ev_d;
   logic [1:0]      pend_q;
   logic [1:0]      pend_d;

   logic [2:0]      state_q;
   logic [2:0]      state_d;
   logic [7:0]      cnt_q;
   logic [7:0]      cnt_d;
   logic            s_q;
   logic            s_d;
   logic            r_q;
   logic            r_d;
   logic            exp_q;
   logic            exp_d;
   logic            fault_q;
   logic            fault_d;
   logic            leave;

   assign req_s = {rst_sync_q[1], set_sync_q[1]};

   always_comb begin
      deb_d  = deb_q;
      dcnt_d = dcnt_q;
      ev_d   = '0;
      for (int i = 0; i < 2; i++) begin
         if (req_s[i] == deb_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DEB_LAST) begin
            deb_d[i]  = req_s[i];
            dcnt_d[i] = '0;
            ev_d[i]   = req_s[i];
         end else begin
            dcnt_d[i] = dcnt_q[i] + 8'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_d     = 1'b0;
      r_d     = 1'b0;
      exp_d   = exp_q;
      fault_d = fault_q;
      leave   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // reset request dominates a simultaneous set
            if (pend_q[1]) begin
               state_d = ST_RST;
               cnt_d   = '0;
               r_d     = 1'b1;
               exp_d   = 1'b0;
               leave   = 1'b1;
            end else if (pend_q[0]) begin
               state_d = ST_SET;
               cnt_d   = '0;
               s_d     = 1'b1;
               exp_d   = 1'b1;
               leave   = 1'b1;
            end
         end
         ST_SET: begin
            if (cnt_q == PUL_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
               s_d   = 1'b1;
            end
         end
         ST_RST: begin
            if (cnt_q == PUL_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
               r_d   = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_CHK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_CHK: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (qfb_sync_q[1] != exp_q) fault_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // events landing on the IDLE exit edge survive the clear
   assign pend_d = (leave ? 2'b00 : pend_q) | ev_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         set_sync_q <= '0;
         rst_sync_q <= '0;
         qfb_sync_q <= '0;
         deb_q      <= '0;
         dcnt_q     <= '0;
         ev_q       <= '0;
         pend_q     <= '0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         exp_q      <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         set_sync_q <= {set_sync_q[0], SET_REQ};
         rst_sync_q <= {rst_sync_q[0], RESET_REQ};
         qfb_sync_q <= {qfb_sync_q[0], Q_FB};
         deb_q      <= deb_d;
         dcnt_q     <= dcnt_d;
         ev_q       <= ev_d;
         pend_q     <= pend_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s_q        <= s_d;
         r_q        <= r_d;
         exp_q      <= exp_d;
         fault_q    <= fault_d;
      end
   end

   assign S         = s_q;
   assign R         = r_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign STATE_EXP = exp_q;
   assign FAULT     = fault_q;

endmodule

// File: tb/tb_sr_drive_controller.sv
// Bench for sr_drive_controller: directed scenarios plus random button traffic,
// every cycle compared against a history-based behavioural model.
module tb_sr_drive_controller;

   localparam int D = 4;
   localparam int P = 3;
   localparam int G = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic SET_REQ = 1'b0;
   logic RESET_REQ = 1'b0;
   logic Q_FB;
   logic S, R, BUSY, STATE_EXP, FAULT;

   logic latch_q = 1'b0;
   logic tie_low = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic smp_s, smp_r, smp_q;
   logic hs[$];
   logic hr[$];
   logic hq[$];

   logic m_deb_s, m_deb_r, m_ev_s, m_ev_r;
   logic m_pend_s, m_pend_r, m_act, m_set, m_exp, m_fault;
   int   m_k;

   always #5 CLK = ~CLK;

   // behavioural SR latch driven by the DUT, optionally stuck low
   always @(posedge CLK) begin
      if (S) latch_q <= 1'b1;
      else if (R) latch_q <= 1'b0;
   end
   assign Q_FB = tie_low ? 1'b0 : latch_q;

   sr_drive_controller #(
      .DEBOUNCE_CYCLES(D),
      .PULSE_CYCLES(P),
      .GAP_CYCLES(G)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .SET_REQ(SET_REQ),
      .RESET_REQ(RESET_REQ),
      .Q_FB(Q_FB),
      .S(S),
      .R(R),
      .BUSY(BUSY),
      .STATE_EXP(STATE_EXP),
      .FAULT(FAULT)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic hist(input int which, input int idx);
      if (idx < 0) return 1'b0;
      case (which)
         0: return hs[idx];
         1: return hr[idx];
         default: return hq[idx];
      endcase
   endfunction

   // level flips once the last D synchronized samples all disagree with it
   function automatic logic deb_step(input int which, input logic deb, input int n);
      for (int i = 0; i < D; i++)
         if (hist(which, n - 2 - i) == deb) return deb;
      return ~deb;
   endfunction

   function automatic logic [4:0] dut_o();
      return {S, R, BUSY, STATE_EXP, FAULT};
   endfunction

   function automatic logic [4:0] mdl_o();
      logic pulse;
      pulse = m_act && (m_k < P);
      return {pulse && m_set, pulse && !m_set, m_act, m_exp, m_fault};
   endfunction

   task automatic model_reset();
      hs.delete();
      hr.delete();
      hq.delete();
      m_deb_s = 0; m_deb_r = 0; m_ev_s = 0; m_ev_r = 0;
      m_pend_s = 0; m_pend_r = 0; m_act = 0; m_set = 0;
      m_exp = 0; m_fault = 0; m_k = 0;
   endtask

   task automatic model_edge();
      int n;
      logic ds, dr;
      n = hs.size();
      hs.push_back(smp_s);
      hr.push_back(smp_r);
      hq.push_back(smp_q);
      if (m_act) begin
         m_k++;
         if (m_k == P + G + 1) begin
            if (hist(2, n - 2) != m_exp) m_fault = 1'b1;
            m_act = 1'b0;
         end
      end else if (m_pend_r || m_pend_s) begin
         m_act = 1'b1;
         m_k = 0;
         m_set = !m_pend_r;
         m_exp = m_set;
         m_pend_r = 1'b0;
         m_pend_s = 1'b0;
      end
      m_pend_s = m_pend_s | m_ev_s;
      m_pend_r = m_pend_r | m_ev_r;
      ds = deb_step(0, m_deb_s, n);
      dr = deb_step(1, m_deb_r, n);
      m_ev_s = ds && !m_deb_s;
      m_ev_r = dr && !m_deb_r;
      m_deb_s = ds;
      m_deb_r = dr;
   endtask

   task automatic tick();
      @(negedge CLK);
      smp_s = SET_REQ;
      smp_r = RESET_REQ;
      smp_q = Q_FB;
      @(posedge CLK);
      model_edge();
      #1;
      check("cycle", int'(dut_o()), int'(mdl_o()));
   endtask

   task automatic do_reset(input string tag);
      #2 RST = 1'b1;
      #1;
      model_reset();
      check(tag, int'(dut_o()), 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   int s_rise, s_hi, r_hi, b_hi, ovl, rises, k0;
   logic prev_s, prev_b, prev_f, fall_seen;

   initial begin
      model_reset();
      do_reset("reset_init");

      // clean set
      SET_REQ = 1'b1;
      s_rise = 0; s_hi = 0; r_hi = 0; b_hi = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (S && s_rise == 0) s_rise = k;
         s_hi += int'(S);
         r_hi += int'(R);
         b_hi += int'(BUSY);
      end
      check("set_latency", s_rise - 1, D + 3);
      check("set_width", s_hi, P);
      check("set_r_quiet", r_hi, 0);
      check("set_busy_len", b_hi, P + G + 1);
      check("set_exp", int'(STATE_EXP), 1);
      check("set_fault", int'(FAULT), 0);

      // bounce rejection
      SET_REQ = 1'b0;
      repeat (10) tick();
      rises = 0; prev_s = S;
      for (int j = 0; j < 5; j++) begin
         SET_REQ = 1'b1;
         repeat ((j % 3) + 1) begin
            tick();
            if (S && !prev_s) rises++;
            prev_s = S;
         end
         SET_REQ = 1'b0;
         repeat ((j % 2) + 1) begin
            tick();
            if (S && !prev_s) rises++;
            prev_s = S;
         end
      end
      check("bounce_no_pulse", rises, 0);
      SET_REQ = 1'b1;
      s_rise = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (S && !prev_s) begin
            rises++;
            if (s_rise == 0) s_rise = k;
         end
         prev_s = S;
      end
      check("bounce_one_pulse", rises, 1);
      check("bounce_latency", s_rise - 1, D + 3);

      // simultaneous requests
      SET_REQ = 1'b0;
      repeat (10) tick();
      SET_REQ = 1'b1;
      RESET_REQ = 1'b1;
      s_hi = 0; r_hi = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         s_hi += int'(S);
         r_hi += int'(R);
      end
      check("simul_s", s_hi, 0);
      check("simul_r", r_hi, P);
      check("simul_exp", int'(STATE_EXP), 0);

      // reset request queued behind a busy set
      SET_REQ = 1'b0;
      RESET_REQ = 1'b0;
      repeat (10) tick();
      SET_REQ = 1'b1;
      k0 = 0;
      while (!BUSY && k0 < 20) begin
         tick();
         k0++;
      end
      check("queue_busy", int'(BUSY), 1);
      RESET_REQ = 1'b1;
      r_hi = 0; ovl = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         r_hi += int'(R);
         ovl += int'(S && R);
      end
      check("queue_r", r_hi, P);
      check("queue_overlap", ovl, 0);
      check("queue_exp", int'(STATE_EXP), 0);

      // readback fault with Q stuck low
      SET_REQ = 1'b0;
      RESET_REQ = 1'b0;
      repeat (10) tick();
      tie_low = 1'b1;
      SET_REQ = 1'b1;
      fall_seen = 1'b0;
      prev_b = BUSY;
      prev_f = FAULT;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (prev_b && !BUSY && !fall_seen) begin
            fall_seen = 1'b1;
            check("fault_edge", int'({prev_f, FAULT}), 1);
         end
         prev_b = BUSY;
         prev_f = FAULT;
      end
      check("fault_seen", int'(fall_seen), 1);
      SET_REQ = 1'b0;
      repeat (10) tick();
      tie_low = 1'b0;
      RESET_REQ = 1'b1;
      repeat (20) tick();
      check("fault_sticky", int'(FAULT), 1);
      RESET_REQ = 1'b0;
      repeat (10) tick();

      // reset during the second S cycle
      SET_REQ = 1'b1;
      k0 = 0;
      while (!S && k0 < 20) begin
         tick();
         k0++;
      end
      check("mid_s_seen", int'(S), 1);
      tick();
      check("mid_s_second", int'(S), 1);
      SET_REQ = 1'b0;
      do_reset("rst_mid");
      b_hi = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         b_hi += int'(S) + int'(R) + int'(BUSY);
      end
      check("post_rst_quiet", b_hi, 0);

      // random button traffic
      for (int seg = 0; seg < 40; seg++) begin
         SET_REQ = ($urandom_range(0, 1) == 1);
         RESET_REQ = ($urandom_range(0, 1) == 1);
         tie_low = ($urandom_range(0, 7) == 0);
         repeat ($urandom_range(1, 12)) tick();
         if (seg == 20) do_reset("rst_rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
